mcl_hs_stim_ctrl: RTL and testbench

Synthesizable stimulus/response controller for avail/get pipelines such as the MCL sine datapath. It issues NUM_SAMPLES words from an external sample memory into a DUT input port, throttled by independent LFSRs on the pre and post sides. It collects DUT outputs in order, bounds outstanding transactions, and measures per-sample latency through a timestamp FIFO. It is used both in benches and on-chip for self-test.

---
 rtl/mcl_stim_pkg.sv | 36 +++
 rtl/mcl_ts_fifo.sv | 56 +++++
 rtl/mcl_hs_stim_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_mcl_hs_stim_ctrl.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcl_stim_pkg.sv
// Shared types and helpers for the MCL handshake stimulus controller:
// FSM state and throttle-mode encodings, LFSR reset value, tap mask and step function.
package mcl_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } stim_state_e;

    typedef enum logic [1:0] {
        THR_NONE = 2'd0,
        THR_PRE  = 2'd1,
        THR_POST = 2'd2,
        THR_BOTH = 2'd3
    } throttle_mode_e;

    localparam logic [15:0] LFSR_RESET = 16'hACE1;

    // Fibonacci taps 16,14,13,11 expressed on a right-shifting register (bits 0,2,3,5)
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

    function automatic logic [15:0] bit_rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int unsigned i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/mcl_ts_fifo.sv
// Timestamp FIFO: synchronous, power-of-two depth, fall-through head (rdata valid
// whenever empty is low), synchronous clear for the start of a new run.
module mcl_ts_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage array, written on push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mcl_hs_stim_ctrl.sv
// Stimulus/response controller for avail/get pipelines: issues NUM_SAMPLES words,
// collects results in order, bounds outstanding transactions, measures latency.
// Optional drain watchdog enabled by defining MCL_STIM_TIMEOUT_EN.
module mcl_hs_stim_ctrl
    import mcl_stim_pkg::*;
#(
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned NUM_SAMPLES    = 1024,
    parameter int unsigned IDX_W          = $clog2(NUM_SAMPLES),
    parameter int unsigned MAX_INFLIGHT   = 16,
    parameter int unsigned TS_W           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        throttle_mode,
    input  logic [15:0]       lfsr_seed,
    output logic [IDX_W-1:0]  src_idx,
    input  logic [DATA_W-1:0] src_data,
    output logic              pre_avail,
    input  logic              pre_get,
    output logic [DATA_W-1:0] pre_data,
    input  logic              post_avail,
    output logic              post_get,
    input  logic [DATA_W-1:0] post_data,
    output logic              sink_valid,
    output logic [IDX_W-1:0]  sink_idx,
    output logic [DATA_W-1:0] sink_data,
    output logic [TS_W-1:0]   lat_last,
    output logic [TS_W-1:0]   lat_max,
    output logic              busy,
    output logic              done,
    output logic              err_underflow,
    output logic              err_timeout
);

    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned INF_W = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [CNT_W-1:0] NUM_C = CNT_W'(NUM_SAMPLES);
    localparam logic [INF_W-1:0] MAX_C = INF_W'(MAX_INFLIGHT);

    stim_state_e       state;
    throttle_mode_e    mode_q;
    logic [15:0]       pre_lfsr;
    logic [15:0]       post_lfsr;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  collect_cnt;
    logic [INF_W-1:0]  inflight;
    logic [TS_W-1:0]   cycle_cnt;
    logic              pre_avail_q;
    logic              sink_valid_q;
    logic [IDX_W-1:0]  sink_idx_q;
    logic [DATA_W-1:0] sink_data_q;
    logic [TS_W-1:0]   lat_last_q;
    logic [TS_W-1:0]   lat_max_q;
    logic              err_underflow_q;

    logic              busy_c;
    logic              start_ok;
    logic [15:0]       seed_eff;
    logic              pre_gate;
    logic              post_gate;
    logic              pre_xfer;
    logic              post_xfer;
    logic              bypass;
    logic              underflow_ev;
    logic              collect_ev;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [TS_W-1:0]   fifo_head;
    logic [TS_W-1:0]   ts_sel;
    logic [TS_W-1:0]   lat_now;
    logic [CNT_W-1:0]  issue_nxt;
    logic [INF_W-1:0]  inflight_nxt;
    logic              pre_raise;
    logic              pre_avail_nxt;

    // Handshake qualification, FIFO control and next-state of the counters
    always_comb begin
        busy_c    = (state == RUN) || (state == DRAIN);
        start_ok  = start && ((state == IDLE) || (state == DONE));
        seed_eff  = (lfsr_seed == 16'h0000) ? LFSR_RESET : lfsr_seed;
        pre_gate  = !((mode_q == THR_PRE) || (mode_q == THR_BOTH)) || pre_lfsr[0];
        post_gate = !((mode_q == THR_POST) || (mode_q == THR_BOTH)) || post_lfsr[0];
        pre_xfer  = pre_avail_q && pre_get;
        post_xfer = post_avail && busy_c && post_gate;
        // A word accepted and returned in the same cycle on an empty FIFO never
        // touches storage: its timestamp is the current cycle (latency 0).
        bypass       = pre_xfer && post_xfer && fifo_empty;
        underflow_ev = post_xfer && (inflight == '0) && !pre_xfer;
        collect_ev   = post_xfer && !underflow_ev;
        fifo_push    = pre_xfer && !bypass;
        fifo_pop     = collect_ev && !bypass;
        ts_sel       = bypass ? cycle_cnt : fifo_head;
        lat_now      = cycle_cnt - ts_sel;
        issue_nxt    = issue_cnt + CNT_W'(pre_xfer);
        inflight_nxt = inflight;
        if (pre_xfer && !collect_ev)      inflight_nxt = inflight + 1'b1;
        else if (collect_ev && !pre_xfer) inflight_nxt = inflight - 1'b1;
        pre_raise = (state == RUN) && (issue_nxt < NUM_C) && (inflight_nxt < MAX_C)
                    && !(fifo_full && !fifo_pop) && pre_gate;
        pre_avail_nxt = (pre_avail_q && !pre_get) || pre_raise;
    end

`ifdef MCL_STIM_TIMEOUT_EN
    logic [TS_W-1:0] wd_cnt;
    logic            err_timeout_q;
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    // Run-control FSM with all registered outputs and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            mode_q          <= THR_NONE;
            pre_lfsr        <= LFSR_RESET;
            post_lfsr       <= LFSR_RESET;
            issue_cnt       <= '0;
            collect_cnt     <= '0;
            inflight        <= '0;
            cycle_cnt       <= '0;
            pre_avail_q     <= 1'b0;
            sink_valid_q    <= 1'b0;
            sink_idx_q      <= '0;
            sink_data_q     <= '0;
            lat_last_q      <= '0;
            lat_max_q       <= '0;
            err_underflow_q <= 1'b0;
`ifdef MCL_STIM_TIMEOUT_EN
            wd_cnt          <= '0;
            err_timeout_q   <= 1'b0;
`endif
        end else begin
            sink_valid_q <= 1'b0;
            cycle_cnt    <= cycle_cnt + 1'b1;
            unique case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state           <= RUN;
                        mode_q          <= throttle_mode_e'(throttle_mode);
                        pre_lfsr        <= seed_eff;
                        post_lfsr       <= bit_rev16(seed_eff);
                        issue_cnt       <= '0;
                        collect_cnt     <= '0;
                        inflight        <= '0;
                        cycle_cnt       <= '0;
                        lat_last_q      <= '0;
                        lat_max_q       <= '0;
                        err_underflow_q <= 1'b0;
`ifdef MCL_STIM_TIMEOUT_EN
                        wd_cnt          <= '0;
                        err_timeout_q   <= 1'b0;
`endif
                    end
                end
                RUN, DRAIN: begin
                    pre_lfsr    <= lfsr_next(pre_lfsr);
                    post_lfsr   <= lfsr_next(post_lfsr);
                    issue_cnt   <= issue_nxt;
                    inflight    <= inflight_nxt;
                    pre_avail_q <= pre_avail_nxt;
                    if (collect_ev) begin
                        collect_cnt  <= collect_cnt + 1'b1;
                        lat_last_q   <= lat_now;
                        lat_max_q    <= (lat_now > lat_max_q) ? lat_now : lat_max_q;
                        sink_valid_q <= 1'b1;
                        sink_idx_q   <= collect_cnt[IDX_W-1:0];
                        sink_data_q  <= post_data;
                    end
                    if (underflow_ev) err_underflow_q <= 1'b1;
                    if ((state == RUN) && (issue_cnt == NUM_C))     state <= DRAIN;
                    if ((state == DRAIN) && (collect_cnt == NUM_C)) state <= DONE;
`ifdef MCL_STIM_TIMEOUT_EN
                    if (post_xfer || (inflight == '0)) begin
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (wd_cnt == TS_W'(TIMEOUT_CYCLES - 1)) begin
                            err_timeout_q <= 1'b1;
                            pre_avail_q   <= 1'b0;
                            state         <= DONE;
                        end
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    mcl_ts_fifo #(
        .WIDTH (TS_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_ts_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (cycle_cnt),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign src_idx       = issue_cnt[IDX_W-1:0];
    assign pre_data      = src_data;
    assign pre_avail     = pre_avail_q;
    assign post_get      = busy_c && post_gate;
    assign sink_valid    = sink_valid_q;
    assign sink_idx      = sink_idx_q;
    assign sink_data     = sink_data_q;
    assign lat_last      = lat_last_q;
    assign lat_max       = lat_max_q;
    assign busy          = busy_c;
    assign done          = (state == DONE);
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_mcl_hs_stim_ctrl.sv
// Directed bench for mcl_hs_stim_ctrl with a behavioural DUT (loopback or
// fixed-latency queue). Build with MCL_STIM_TIMEOUT_EN to add the watchdog scenario.
module tb_mcl_hs_stim_ctrl;

    localparam int NS = 32;
    localparam int IW = $clog2(NS);
    localparam int DW = 64;
    localparam int TW = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    throttle_mode;
    logic [15:0]   lfsr_seed;
    logic [IW-1:0] src_idx;
    logic [DW-1:0] src_data;
    logic          pre_avail;
    logic          pre_get;
    logic [DW-1:0] pre_data;
    logic          post_avail;
    logic          post_get;
    logic [DW-1:0] post_data;
    logic          sink_valid;
    logic [IW-1:0] sink_idx;
    logic [DW-1:0] sink_data;
    logic [TW-1:0] lat_last;
    logic [TW-1:0] lat_max;
    logic          busy;
    logic          done;
    logic          err_underflow;
    logic          err_timeout;

    mcl_hs_stim_ctrl #(
        .DATA_W         (DW),
        .NUM_SAMPLES    (NS),
        .MAX_INFLIGHT   (16),
        .TS_W           (TW),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .throttle_mode (throttle_mode),
        .lfsr_seed     (lfsr_seed),
        .src_idx       (src_idx),
        .src_data      (src_data),
        .pre_avail     (pre_avail),
        .pre_get       (pre_get),
        .pre_data      (pre_data),
        .post_avail    (post_avail),
        .post_get      (post_get),
        .post_data     (post_data),
        .sink_valid    (sink_valid),
        .sink_idx      (sink_idx),
        .sink_data     (sink_data),
        .lat_last      (lat_last),
        .lat_max       (lat_max),
        .busy          (busy),
        .done          (done),
        .err_underflow (err_underflow),
        .err_timeout   (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sample memory: word i = {DA7A5A5A, zeros, i}
    assign src_data = {32'hDA7A_5A5A, 27'd0, src_idx};

    // Behavioural DUT controls
    bit   kind;          // 0: zero-latency loopback, 1: latency queue
    int   lat_cfg;
    bit   hold_post;
    bit   force_post;
    bit   rand_get;
    int   drop_idx;
    bit   mon_clr;
    bit   pre_get_drv;
    bit   pg_pat [0:1023];

    logic [DW-1:0] rb_data [0:63];
    int            rb_rdy  [0:63];
    int            wp, rp;

    // Monitor state
    int            cyc_rel, n_pre, n_post, n_sink, viol, peak, n_gate;
    int            last_post_cyc, first_to;
    bit            to_seen, prev_wait;
    logic [DW-1:0] prev_data;
    logic [IW-1:0] s_idx  [0:63];
    logic [DW-1:0] s_data [0:63];
    logic [TW-1:0] s_lat  [0:63];
    int            s_cyc  [0:63];
    int            ref_cyc [0:63];
    int            ref_n;

    int n_checks;
    int n_fails;

    assign pre_get    = (kind == 1'b0) ? 1'b1 : pre_get_drv;
    assign post_avail = force_post | ((kind == 1'b0) ? pre_avail :
                        (!hold_post && (wp != rp) && (rb_rdy[rp % 64] <= cyc_rel)));
    assign post_data  = (kind == 1'b0) ? pre_data : rb_data[rp % 64];

    // DUT model and transfer monitor, both on pre-edge values
    always @(posedge clk) begin
        if (mon_clr) begin
            cyc_rel <= 0; n_pre <= 0; n_post <= 0; n_sink <= 0; viol <= 0; peak <= 0;
            n_gate <= 0; wp <= 0; rp <= 0; prev_wait <= 1'b0; to_seen <= 1'b0;
            last_post_cyc <= 0; first_to <= 0;
        end else begin
            cyc_rel <= cyc_rel + 1;
            if (pre_avail && pre_get) begin
                n_pre <= n_pre + 1;
                if (kind && (n_pre != drop_idx)) begin
                    rb_data[wp % 64] <= pre_data;
                    rb_rdy[wp % 64]  <= cyc_rel + lat_cfg;
                    wp <= wp + 1;
                end
            end
            if (post_avail && post_get) begin
                n_post        <= n_post + 1;
                last_post_cyc <= cyc_rel;
                if (kind && (wp != rp)) rp <= rp + 1;
            end
            if ((n_pre - n_post) > peak) peak <= n_pre - n_post;
            if (prev_wait && (!pre_avail || (pre_data != prev_data))) viol <= viol + 1;
            prev_wait <= pre_avail && !pre_get;
            prev_data <= pre_data;
            if (busy && !post_get) n_gate <= n_gate + 1;
            if (err_timeout && !to_seen) begin
                to_seen  <= 1'b1;
                first_to <= cyc_rel;
            end
            if (sink_valid && (n_sink < 64)) begin
                s_idx[n_sink]  <= sink_idx;
                s_data[n_sink] <= sink_data;
                s_lat[n_sink]  <= lat_last;
                s_cyc[n_sink]  <= cyc_rel;
                n_sink <= n_sink + 1;
            end
        end
    end

    // pre_get pattern replayed from the run-relative cycle so repeated runs are identical
    initial begin
        pre_get_drv = 1'b1;
        forever begin
            @(negedge clk);
            pre_get_drv = rand_get ? pg_pat[cyc_rel % 1024] : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic do_start(input logic [1:0] m, input logic [15:0] sd);
        mon_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mon_clr       = 1'b0;
        throttle_mode = m;
        lfsr_seed     = sd;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL %s_done: done not reached within %0d cycles", name, budget);
        end
    endtask

    task automatic check_order(input string name);
        logic [DW-1:0] exp;
        n_checks++;
        if (n_sink !== NS) begin
            n_fails++;
            $display("FAIL %s_count: got %0d want %0d", name, n_sink, NS);
        end
        for (int i = 0; i < NS; i++) begin
            exp = {32'hDA7A_5A5A, 27'd0, IW'(i)};
            n_checks++;
            if ((s_idx[i] !== IW'(i)) || (s_data[i] !== exp)) begin
                n_fails++;
                $display("FAIL %s_item%0d: got idx %0d data %h want idx %0d data %h",
                         name, i, s_idx[i], s_data[i], i, exp);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({pre_avail, post_get, sink_valid, busy, done, err_underflow, err_timeout} !== 7'b0) begin
            n_fails++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {pre_avail, post_get, sink_valid, busy, done, err_underflow, err_timeout});
        end
        n_checks++;
        if ((sink_idx !== '0) || (sink_data !== '0) || (lat_last !== '0) || (lat_max !== '0) || (src_idx !== '0)) begin
            n_fails++;
            $display("FAIL reset_values: sink_idx %0d sink_data %h lat_last %0d lat_max %0d src_idx %0d want all 0",
                     sink_idx, sink_data, lat_last, lat_max, src_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loopback();
        kind = 1'b0;
        do_start(2'd0, 16'h0001);
        wait_done(400, "loop");
        check_order("loop");
        n_checks++;
        if ((done !== 1'b1) || (busy !== 1'b0)) begin
            n_fails++;
            $display("FAIL loop_state: got done %b busy %b want done 1 busy 0", done, busy);
        end
        n_checks++;
        if (lat_max !== 0) begin
            n_fails++;
            $display("FAIL loop_latmax: got %0d want 0", lat_max);
        end
        n_checks++;
        if (err_underflow !== 1'b0) begin
            n_fails++;
            $display("FAIL loop_underflow: got %b want 0", err_underflow);
        end
    endtask

    task automatic test_pipeline();
        kind = 1'b1; lat_cfg = 5; hold_post = 1'b0; rand_get = 1'b0;
        do_start(2'd0, 16'h0001);
        wait_done(600, "pipe");
        check_order("pipe");
        for (int i = 0; i < NS; i++) begin
            n_checks++;
            if (s_lat[i] !== 32'd5) begin
                n_fails++;
                $display("FAIL pipe_lat%0d: got %0d want 5", i, s_lat[i]);
            end
        end
        n_checks++;
        if ((lat_max !== 32'd5) || (lat_last !== 32'd5)) begin
            n_fails++;
            $display("FAIL pipe_latmax: got max %0d last %0d want 5 5", lat_max, lat_last);
        end
        n_checks++;
        if (peak > 6) begin
            n_fails++;
            $display("FAIL pipe_inflight: got peak %0d want <= 6", peak);
        end
        n_checks++;
        if (n_gate !== 0) begin
            n_fails++;
            $display("FAIL pipe_postget: post_get low while busy %0d cycles want 0", n_gate);
        end
    endtask

    task automatic test_stall();
        kind = 1'b1; lat_cfg = 1; hold_post = 1'b1; rand_get = 1'b0;
        do_start(2'd0, 16'h0001);
        repeat (40) @(negedge clk);
        n_checks++;
        if (n_pre !== 16) begin
            n_fails++;
            $display("FAIL stall_issued: got %0d pre transfers want 16", n_pre);
        end
        n_checks++;
        if ((pre_avail !== 1'b0) || (busy !== 1'b1) || (n_sink !== 0)) begin
            n_fails++;
            $display("FAIL stall_state: got pre_avail %b busy %b sinks %0d want 0 1 0", pre_avail, busy, n_sink);
        end
        hold_post = 1'b0;
        wait_done(600, "stall");
        check_order("stall");
    endtask

    task automatic test_throttle();
        kind = 1'b1; lat_cfg = 2; hold_post = 1'b0; rand_get = 1'b1;
        do_start(2'd3, 16'h1234);
        wait_done(4000, "thr1");
        check_order("thr1");
        n_checks++;
        if (viol !== 0) begin
            n_fails++;
            $display("FAIL thr_hold: got %0d retraction/data-change events want 0", viol);
        end
        n_checks++;
        if (n_gate == 0) begin
            n_fails++;
            $display("FAIL thr_postgate: got %0d gated cycles want > 0", n_gate);
        end
        ref_n = n_sink;
        for (int i = 0; i < 64; i++) ref_cyc[i] = s_cyc[i];
        do_start(2'd3, 16'h1234);
        wait_done(4000, "thr2");
        check_order("thr2");
        n_checks++;
        if (n_sink !== ref_n) begin
            n_fails++;
            $display("FAIL thr_repeat_count: got %0d want %0d", n_sink, ref_n);
        end
        for (int i = 0; i < NS; i++) begin
            n_checks++;
            if (s_cyc[i] !== ref_cyc[i]) begin
                n_fails++;
                $display("FAIL thr_repeat%0d: sink cycle got %0d want %0d", i, s_cyc[i], ref_cyc[i]);
            end
        end
    endtask

    task automatic test_seed_zero();
        kind = 1'b1; lat_cfg = 2; hold_post = 1'b0; rand_get = 1'b1;
        do_start(2'd3, 16'hACE1);
        wait_done(4000, "seed_ace1");
        for (int i = 0; i < 64; i++) ref_cyc[i] = s_cyc[i];
        do_start(2'd3, 16'h0000);
        wait_done(4000, "seed_zero");
        check_order("seed_zero");
        for (int i = 0; i < NS; i++) begin
            n_checks++;
            if (s_cyc[i] !== ref_cyc[i]) begin
                n_fails++;
                $display("FAIL seed_zero%0d: sink cycle got %0d want %0d", i, s_cyc[i], ref_cyc[i]);
            end
        end
        rand_get = 1'b0;
    endtask

    task automatic test_underflow();
        kind = 1'b1; lat_cfg = 1; hold_post = 1'b0; rand_get = 1'b0;
        force_post = 1'b1;
        repeat (2) @(negedge clk);
        force_post = 1'b0;
        n_checks++;
        if (err_underflow !== 1'b0) begin
            n_fails++;
            $display("FAIL uf_idle: got err_underflow %b want 0", err_underflow);
        end
        do_start(2'd0, 16'h0001);
        force_post = 1'b1;
        @(negedge clk);
        force_post = 1'b0;
        @(negedge clk);
        n_checks++;
        if ((err_underflow !== 1'b1) || (n_sink !== 0)) begin
            n_fails++;
            $display("FAIL uf_flag: got err_underflow %b sinks %0d want 1 0", err_underflow, n_sink);
        end
        wait_done(600, "uf");
        check_order("uf");
        n_checks++;
        if (err_underflow !== 1'b1) begin
            n_fails++;
            $display("FAIL uf_sticky: got %b want 1", err_underflow);
        end
    endtask

`ifdef MCL_STIM_TIMEOUT_EN
    task automatic test_timeout();
        kind = 1'b1; lat_cfg = 1; hold_post = 1'b0; rand_get = 1'b0; drop_idx = 10;
        do_start(2'd0, 16'h0001);
        wait_done(1000, "to");
        drop_idx = -1;
        n_checks++;
        if ((err_timeout !== 1'b1) || (done !== 1'b1)) begin
            n_fails++;
            $display("FAIL to_flag: got err_timeout %b done %b want 1 1", err_timeout, done);
        end
        n_checks++;
        if (n_sink !== NS - 1) begin
            n_fails++;
            $display("FAIL to_count: got %0d want %0d", n_sink, NS - 1);
        end
        // flag set on the 100th edge after the last post transfer, first seen one cycle later
        n_checks++;
        if ((first_to - last_post_cyc) !== 101) begin
            n_fails++;
            $display("FAIL to_delay: got %0d want 101", first_to - last_post_cyc);
        end
    endtask
`endif

    task automatic test_reset_midrun();
        kind = 1'b1; lat_cfg = 3; hold_post = 1'b0; rand_get = 1'b0;
        do_start(2'd0, 16'h0001);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({pre_avail, post_get, sink_valid, busy, done, err_underflow, err_timeout} !== 7'b0) begin
            n_fails++;
            $display("FAIL rst_mid_flags: got %b want 0000000",
                     {pre_avail, post_get, sink_valid, busy, done, err_underflow, err_timeout});
        end
        n_checks++;
        if ((sink_idx !== '0) || (sink_data !== '0) || (lat_last !== '0) || (lat_max !== '0) || (src_idx !== '0)) begin
            n_fails++;
            $display("FAIL rst_mid_values: sink_idx %0d sink_data %h lat_last %0d lat_max %0d src_idx %0d want all 0",
                     sink_idx, sink_data, lat_last, lat_max, src_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0; n_fails = 0;
        rst_n = 1'b0; start = 1'b0; throttle_mode = 2'd0; lfsr_seed = 16'h0000;
        kind = 1'b0; lat_cfg = 1; hold_post = 1'b0; force_post = 1'b0; rand_get = 1'b0;
        drop_idx = -1; mon_clr = 1'b1; ref_n = 0;
        for (int i = 0; i < 1024; i++) pg_pat[i] = ($urandom_range(0, 99) < 60);
        @(negedge clk);
        test_reset();
        test_loopback();
        test_pipeline();
        test_stall();
        test_throttle();
        test_seed_zero();
        test_underflow();
`ifdef MCL_STIM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
